// File: rtl/gpr_pkg.sv
// Shared types and default sizes for the general-purpose register file.
// Holds the dump walker state encoding and the default data/address widths.
package gpr_pkg;

    localparam int unsigned GPR_DATA_W = 32'd8;
    localparam int unsigned GPR_ADDR_W = 32'd3;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_RUN  = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/gpr_dump_fsm.sv
// Dump walker for the register file: steps an index over every register with a
// valid/ready handshake and flags completion with a one-cycle done pulse.
module gpr_dump_fsm
    import gpr_pkg::*;
#(
    parameter int unsigned ADDR_W = GPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_index
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    dump_state_e       state_r;
    dump_state_e       state_next_s;
    logic [ADDR_W-1:0] index_r;
    logic [ADDR_W-1:0] index_next_s;
    logic              valid_r;
    logic              busy_r;
    logic              done_r;

    // Next state and index; terminal check precedes the increment so the index never wraps
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        case (state_r)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_next_s = DUMP_RUN;
                    index_next_s = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = DUMP_IDLE;
                end
            end
            DUMP_RUN: begin
                if (!dump_ready) begin
                    state_next_s = DUMP_RUN;
                end else if (index_r == LAST_IDX) begin
                    state_next_s = DUMP_DONE;
                end else begin
                    index_next_s = index_r + ADDR_W'(1'b1);
                end
            end
            DUMP_DONE: begin
                state_next_s = DUMP_IDLE;
            end
            default: begin
                state_next_s = DUMP_IDLE;
                index_next_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, index and status flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DUMP_IDLE;
            index_r <= {ADDR_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            index_r <= index_next_s;
            valid_r <= (state_next_s == DUMP_RUN);
            busy_r  <= (state_next_s != DUMP_IDLE);
            done_r  <= (state_next_s == DUMP_DONE);
        end
    end

    assign dump_valid = valid_r;
    assign dump_busy  = busy_r;
    assign dump_done  = done_r;
    assign dump_index = index_r;

endmodule

// File: rtl/gpr_file.sv
// Parametrised register file: one write port, two combinational read ports with
// optional write bypass and hard-wired zero register, plus a handshaked dump port.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W   = GPR_DATA_W,
    parameter int unsigned ADDR_W   = GPR_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic [DATA_W-1:0] reg_read_data_2,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              write_ok_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] dump_data_s;
    logic [ADDR_W-1:0] dump_index_s;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG == 1'b1) && (addr == {ADDR_W{1'b0}});
    endfunction

    function automatic logic bypass_hit(input logic              we,
                                        input logic [ADDR_W-1:0] dest,
                                        input logic [ADDR_W-1:0] addr);
        return (BYPASS == 1'b1) && we && (dest == addr);
    endfunction

    assign write_ok_s = reg_write_en && !is_zero_addr(reg_write_dest);

    // Register array: cleared on reset, otherwise loaded from the write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_ok_s) begin
            mem_r[reg_write_dest] <= reg_write_data;
        end
    end

    // Read port 1: zero masking wins over bypass, bypass wins over stored value
    always_comb begin
        rd1_s = mem_r[reg_read_addr_1];
        if (is_zero_addr(reg_read_addr_1)) begin
            rd1_s = {DATA_W{1'b0}};
        end else if (bypass_hit(reg_write_en, reg_write_dest, reg_read_addr_1)) begin
            rd1_s = reg_write_data;
        end else begin
            rd1_s = mem_r[reg_read_addr_1];
        end
    end

    // Read port 2: same muxing as port 1
    always_comb begin
        rd2_s = mem_r[reg_read_addr_2];
        if (is_zero_addr(reg_read_addr_2)) begin
            rd2_s = {DATA_W{1'b0}};
        end else if (bypass_hit(reg_write_en, reg_write_dest, reg_read_addr_2)) begin
            rd2_s = reg_write_data;
        end else begin
            rd2_s = mem_r[reg_read_addr_2];
        end
    end

    // Dump data shows the stored value only, so a same-edge write is seen a cycle later
    always_comb begin
        dump_data_s = mem_r[dump_index_s];
        if (is_zero_addr(dump_index_s)) begin
            dump_data_s = {DATA_W{1'b0}};
        end else begin
            dump_data_s = mem_r[dump_index_s];
        end
    end

    gpr_dump_fsm #(
        .ADDR_W(ADDR_W)
    ) u_dump_fsm (
        .clk       (clk),
        .rst       (rst),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_busy (dump_busy),
        .dump_done (dump_done),
        .dump_index(dump_index_s)
    );

    assign reg_read_data_1 = rd1_s;
    assign reg_read_data_2 = rd2_s;
    assign dump_addr       = dump_index_s;
    assign dump_data       = dump_data_s;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: two instances (default, and ZERO_REG=1/BYPASS=0)
// share random and directed stimulus and are compared against an array-based model.
module tb_gpr_file;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] wdest;
    logic [7:0] wdata;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       dstart;
    logic       dready;

    logic [7:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
    logic [2:0] da_a, da_b;
    logic       dv_a, db_a, ddone_a, dv_b, db_b, ddone_b;

    int checks   = 0;
    int failures = 0;

    // model: stored contents per instance, dump position (-1 = idle), done pulse
    logic [7:0] mmem [2][DEPTH];
    int         midx   = -1;
    bit         mdone  = 1'b0;
    bit         cmp_en = 1'b0;
    int         beats[$];

    always #5 clk = ~clk;

    gpr_file dut_a (
        .clk(clk), .rst(rst), .reg_write_en(we), .reg_write_dest(wdest), .reg_write_data(wdata),
        .reg_read_addr_1(ra1), .reg_read_addr_2(ra2), .reg_read_data_1(rd1_a), .reg_read_data_2(rd2_a),
        .dump_start(dstart), .dump_ready(dready), .dump_valid(dv_a), .dump_addr(da_a),
        .dump_data(dd_a), .dump_busy(db_a), .dump_done(ddone_a)
    );

    gpr_file #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .reg_write_en(we), .reg_write_dest(wdest), .reg_write_data(wdata),
        .reg_read_addr_1(ra1), .reg_read_addr_2(ra2), .reg_read_data_1(rd1_b), .reg_read_data_2(rd2_b),
        .dump_start(dstart), .dump_ready(dready), .dump_valid(dv_b), .dump_addr(da_b),
        .dump_data(dd_b), .dump_busy(db_b), .dump_done(ddone_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // instance 0: no zero register, bypass on; instance 1: zero register, no bypass
    function automatic logic [7:0] exp_read(input int inst, input logic [2:0] a);
        if (inst == 1 && a == 3'd0) return 8'h00;
        if (inst == 0 && we && wdest == a) return wdata;
        return mmem[inst][a];
    endfunction

    function automatic logic [7:0] exp_dump(input int inst);
        if (inst == 1 && midx == 0) return 8'h00;
        return mmem[inst][midx];
    endfunction

    // Model update on each rising edge from the inputs present at that edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mmem[0][i] = 8'h00;
                mmem[1][i] = 8'h00;
            end
            midx  = -1;
            mdone = 1'b0;
        end else begin
            if (mdone) begin
                mdone = 1'b0;
            end else if (midx >= 0) begin
                if (dready) begin
                    if (midx == DEPTH - 1) begin
                        midx  = -1;
                        mdone = 1'b1;
                    end else begin
                        midx++;
                    end
                end
            end else if (dstart) begin
                midx = 0;
            end
            if (we) begin
                mmem[0][wdest] = wdata;
                if (wdest != 3'd0) mmem[1][wdest] = wdata;
            end
        end
    end

    // Compare both instances against the model mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd1_a", rd1_a, exp_read(0, ra1));
            check("rd2_a", rd2_a, exp_read(0, ra2));
            check("rd1_b", rd1_b, exp_read(1, ra1));
            check("rd2_b", rd2_b, exp_read(1, ra2));
            check("valid_a", dv_a, midx >= 0);
            check("valid_b", dv_b, midx >= 0);
            check("busy_a", db_a, (midx >= 0) || mdone);
            check("busy_b", db_b, (midx >= 0) || mdone);
            check("done_a", ddone_a, mdone);
            check("done_b", ddone_b, mdone);
            if (midx >= 0) begin
                check("daddr_a", da_a, midx);
                check("daddr_b", da_b, midx);
                check("ddata_a", dd_a, exp_dump(0));
                check("ddata_b", dd_b, exp_dump(1));
                if (dready) beats.push_back(int'(da_a));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = 3'(i);
            ra2 = 3'(DEPTH - 1 - i);
            #1;
            check({name, "_rd1_a"}, rd1_a, 8'h00);
            check({name, "_rd2_a"}, rd2_a, 8'h00);
            check({name, "_rd1_b"}, rd1_b, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int cyc;
        rst = 1'b1; we = 1'b0; wdest = 3'd0; wdata = 8'h00;
        ra1 = 3'd0; ra2 = 3'd0; dstart = 1'b0; dready = 1'b1;
        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        check("reset_valid", dv_a, 1'b0);
        check("reset_addr", da_a, 3'd0);
        check("reset_done", ddone_a, 1'b0);

        // preload nonzero data, then a one-cycle reset must clear it
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wdest = 3'(i); wdata = 8'($urandom_range(1, 255));
            step();
        end
        we = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_valid", dv_a, 1'b0);
        sweep_zero("rst_clear");

        // bypass versus registered read of a fresh write
        step();
        we = 1'b1; wdest = 3'd3; wdata = 8'hA5; ra1 = 3'd3;
        #1;
        check("bypass_same_a", rd1_a, 8'hA5);
        check("bypass_same_b", rd1_b, 8'h00);
        step();
        we = 1'b0;
        #1;
        check("bypass_next_a", rd1_a, 8'hA5);
        check("bypass_next_b", rd1_b, 8'hA5);

        // write to r0: dropped only on the zero-register instance
        we = 1'b1; wdest = 3'd0; wdata = 8'hFF; ra1 = 3'd0;
        #1;
        check("zero_same_b", rd1_b, 8'h00);
        check("zero_same_a", rd1_a, 8'hFF);
        step();
        we = 1'b0;
        #1;
        check("zero_next_b", rd1_b, 8'h00);
        check("zero_next_a", rd1_a, 8'hFF);

        // r_i = i*17 then a full-speed dump
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wdest = 3'(i); wdata = 8'(i * 17);
            step();
        end
        we = 1'b0; dready = 1'b1; dstart = 1'b1;
        step();
        dstart = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            check("fast_valid", dv_a, 1'b1);
            check("fast_addr", da_a, k);
            check("fast_data", dd_a, k * 17);
            busy_cnt += int'(db_a);
            step();
        end
        check("fast_done", ddone_a, 1'b1);
        check("fast_done_valid", dv_a, 1'b0);
        busy_cnt += int'(db_a);
        step();
        check("fast_done_gone", ddone_a, 1'b0);
        check("fast_busy_gone", db_a, 1'b0);
        check("fast_busy_cycles", busy_cnt, 9);

        // throttled dump with a stray start pulse and background writes
        beats.delete();
        dstart = 1'b1;
        step();
        dstart = 1'b0;
        cyc = 0;
        while (!ddone_a && cyc < 100) begin
            dready = (cyc % 3 == 0);
            dstart = (cyc == 5);
            we = 1'($urandom_range(0, 1)); wdest = 3'($urandom); wdata = 8'($urandom);
            step();
            cyc++;
        end
        we = 1'b0; dstart = 1'b0; dready = 1'b1;
        check("slow_done_seen", ddone_a, 1'b1);
        check("slow_beat_count", beats.size(), DEPTH);
        for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
            check("slow_beat_order", beats[i], i);
        end
        step();

        // random traffic including dumps, throttling and occasional reset
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            we     = 1'($urandom_range(0, 1));
            wdest  = 3'($urandom);
            wdata  = 8'($urandom);
            ra1    = 3'($urandom);
            ra2    = 3'($urandom);
            dstart = ($urandom_range(0, 7) == 0);
            dready = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; we = 1'b0; dstart = 1'b0; dready = 1'b1;
        repeat (12) step();

        // reset during beat 4 aborts the dump
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wdest = 3'(i); wdata = 8'(i + 8'h40);
            step();
        end
        we = 1'b0; dstart = 1'b1;
        step();
        dstart = 1'b0;
        cyc = 0;
        while (!(dv_a && da_a == 3'd4) && cyc < 20) begin
            step();
            cyc++;
        end
        check("abort_reached_beat4", da_a, 3'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", dv_a, 1'b0);
        check("abort_busy", db_a, 1'b0);
        check("abort_done", ddone_a, 1'b0);
        sweep_zero("abort_clear");
        step();
        check("abort_no_late_done", ddone_a, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised general-purpose register file; successor to the fixed 8×8 GPR block in the processor datapath. Provides one write port and two asynchronous read ports with write-to-read bypass, an optional hard-wired zero register, synchronous clear on reset, and a handshaked dump port. The dump port streams every register out in address order for the testbench or debug logic, replacing fixed-time file dumps. Sits between the decode stage (read addresses), the writeback stage (write port) and the debug/scoreboard harness (dump port).

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = read port returns write data when addresses match in the same cycle
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- reg_write_en  in  1  write enable
- reg_write_dest  in  ADDR_W  write address
- reg_write_data  in  DATA_W  write data
- reg_read_addr_1 / reg_read_addr_2  in  ADDR_W  read addresses
- reg_read_data_1 / reg_read_data_2  out  DATA_W  read data (combinational)
- dump_start  in  1  request full-file dump (pulse or level)
- dump_ready  in  1  consumer ready
- dump_valid  out  1  dump_addr/dump_data valid
- dump_addr  out  ADDR_W  register index being dumped
- dump_data  out  DATA_W  contents of that register
- dump_busy  out  1  dump in progress (RUN or DONE state)
- dump_done  out  1  one-cycle pulse after the last beat

## Operation
- Reset: all DEPTH registers are cleared to 0. FSM goes to IDLE. dump_valid, dump_busy and dump_done are 0. dump_addr is 0. rst has priority over writes and over the dump in progress.
- Write: when reg_write_en=1, reg_write_dest is loaded on the edge. With ZERO_REG=1, writes to address 0 are dropped.
- Read: reg_read_data_n = array[reg_read_addr_n].
  - With ZERO_REG=1, address 0 reads as 0.
  - With BYPASS=1, if reg_write_en=1 and reg_write_dest equals reg_read_addr_n (and is not the zero register), the port returns reg_write_data in that same cycle.
- Dump FSM states are IDLE, RUN and DONE.
  - IDLE: dump_start=1 -> RUN, with index set to 0. While not in IDLE, dump_start is ignored.
  - RUN: dump_valid=1, dump_addr=index, dump_data=array[index]. dump_data reflects the stored value only: no bypass, and ZERO_REG masking applies.
    - A beat completes when dump_valid and dump_ready are both 1 at the edge.
    - If index=DEPTH-1, go to DONE; otherwise increment index.
    - While dump_ready=0, dump_addr and dump_data stay stable. dump_data may change only if a write targets the held index; that write is visible on the next cycle.
  - DONE: dump_done=1 and dump_valid=0 for one cycle, then IDLE.
- Normal writes and reads continue unaffected during a dump.
- The index counter is ADDR_W bits wide. It never wraps inside a dump because the terminal check happens before the increment.

## Timing
- Write latency is 1 cycle: data is visible on a non-bypassed read in the cycle after the edge.
- Read ports are combinational from the address.
- Dump start: dump_start sampled at edge N gives dump_valid=1 in cycle N+1.
- With dump_ready held at 1, a dump takes DEPTH beat cycles plus 1 DONE cycle. dump_busy stays high for all DEPTH+1 cycles.
- Simultaneous write and dump beat on the same index: the beat carries the old value.
- rst asserted mid-dump: the next cycle shows dump_valid=0, dump_busy=0, no dump_done, and the array cleared.

## Structure
- Package gpr_pkg holds:
  - the dump state enum (IDLE/RUN/DONE);
  - the default parameter constants (DATA_W=8, ADDR_W=3).
- Sub-module gpr_dump_fsm holds the state register, index counter and handshake. It outputs the index used to drive the array read mux. The top level holds the array, the write logic and the bypass/zero muxes.

## Test plan
- Reset: preload registers, assert rst for one cycle -> all reads return 0 and dump_valid=0.
- Write 8'hA5 to r3 with read_addr_1=3 in the same cycle -> BYPASS=1 returns A5 in that cycle; BYPASS=0 returns 0, then A5 the next cycle.
- ZERO_REG=1: write 8'hFF to r0 -> read_data returns 0 both in the same cycle and afterwards.
- Load r_i = i*17, pulse dump_start with dump_ready=1 -> 8 beats with addr 0..7 and data 00,11,…,77, dump_done the cycle after the last beat, busy for 9 cycles.
- Dump with dump_ready toggled (pattern 1,0,0,1…) -> addr/data hold while ready=0, no beat skipped or duplicated. dump_start pulsed mid-dump is ignored.
- Assert rst during beat 4 of a dump -> dump aborts, no dump_done, dump_valid=0 next cycle, array all zeros.
